// File: rtl/crosswalk_pkg.sv
// rtl/crosswalk_pkg.sv - shared state encoding and default timing for the crosswalk array
// Purpose: per-channel walk/stop state type and default timing constants.
// Ports: none (package).
package crosswalk_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_WALK  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_WALK_TIME  = 10;
  localparam int DEF_BLINK_DIV  = 2;
  localparam int DEF_CLEAR_TIME = 32;
  localparam int DEF_TIMER_W    = 8;

endpackage

// File: rtl/crosswalk_chan.sv
// rtl/crosswalk_chan.sv - one crossing: walk/stop FSM, phase timer and request latch
// Purpose: pedestrian signal head controller slaved to one traffic-light phase.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   red, ylw, grn     traffic phase for this crossing
//   cross_button      synchronised pedestrian request level
//   walk_light        registered walk lamp
//   stop_light        registered stop lamp (blinks during clearance)
//   req_pending       request latched and not yet served
module crosswalk_chan
  import crosswalk_pkg::*;
#(
  parameter int WALK_TIME  = DEF_WALK_TIME,
  parameter int BLINK_DIV  = DEF_BLINK_DIV,
  parameter int CLEAR_TIME = DEF_CLEAR_TIME,
  parameter int TIMER_W    = DEF_TIMER_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic red,
  input  logic ylw,
  input  logic grn,
  input  logic cross_button,
  output logic walk_light,
  output logic stop_light,
  output logic req_pending
);

  localparam logic [TIMER_W-1:0] WALK_LAST  = TIMER_W'(WALK_TIME - 1);
  localparam logic [TIMER_W-1:0] CLEAR_LAST = TIMER_W'(CLEAR_TIME - 1);
  localparam logic [TIMER_W-1:0] BLINK_LAST = TIMER_W'(BLINK_DIV - 1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] blink_q, blink_d;
  logic               req_q, req_d;
  logic               grn_q;
  logic               walk_q, walk_d;
  logic               stop_q, stop_d;
  logic               grn_rise;

  always_comb begin
    grn_rise = grn & ~grn_q;
    state_d  = state_q;
    timer_d  = '0;
    blink_d  = '0;
    req_d    = req_q | cross_button;
    walk_d   = 1'b0;
    stop_d   = 1'b1;

    // Red wins over everything; the request latch keeps collecting presses.
    if (red) begin
      state_d = ST_STOP;
    end else begin
      case (state_q)
        ST_STOP: begin
          // A press in the same cycle as the green edge is served directly,
          // so req never becomes visible.
          if ((req_q | cross_button) & grn_rise) begin
            state_d = ST_WALK;
            walk_d  = 1'b1;
            stop_d  = 1'b0;
            req_d   = 1'b0;
          end
        end
        ST_WALK: begin
          stop_d = 1'b0;
          if (timer_q == WALK_LAST) begin
            state_d = ST_CLEAR;
          end else begin
            timer_d = timer_q + 1'b1;
            walk_d  = 1'b1;
          end
        end
        ST_CLEAR: begin
          if (ylw || (timer_q == CLEAR_LAST)) begin
            state_d = ST_STOP;
          end else begin
            timer_d = timer_q + 1'b1;
            // stop_light entered CLEAR at 0; flip it each BLINK_DIV cycles.
            if (blink_q == BLINK_LAST) begin
              stop_d = ~stop_q;
            end else begin
              blink_d = blink_q + 1'b1;
              stop_d  = stop_q;
            end
          end
        end
        default: state_d = ST_STOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
      timer_q <= '0;
      blink_q <= '0;
      req_q   <= 1'b0;
      grn_q   <= 1'b0;
      walk_q  <= 1'b0;
      stop_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
      req_q   <= req_d;
      grn_q   <= grn;
      walk_q  <= walk_d;
      stop_q  <= stop_d;
    end
  end

  assign walk_light  = walk_q;
  assign stop_light  = stop_q;
  assign req_pending = req_q;

endmodule

// File: rtl/crosswalk_array.sv
// rtl/crosswalk_array.sv - N_CH independent pedestrian crossing controllers
// Purpose: replicates crosswalk_chan per crossing and slices the port vectors.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   red/ylw/grn_trffc_light [N_CH]   per-channel traffic phase
//   cross_button [N_CH]              per-channel pedestrian request level
//   walk_light, stop_light [N_CH]    registered pedestrian lamps
//   req_pending [N_CH]               latched, unserved requests
module crosswalk_array
  import crosswalk_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int WALK_TIME  = DEF_WALK_TIME,
  parameter int BLINK_DIV  = DEF_BLINK_DIV,
  parameter int CLEAR_TIME = DEF_CLEAR_TIME,
  parameter int TIMER_W    = DEF_TIMER_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] red_trffc_light,
  input  logic [N_CH-1:0] ylw_trffc_light,
  input  logic [N_CH-1:0] grn_trffc_light,
  input  logic [N_CH-1:0] cross_button,
  output logic [N_CH-1:0] walk_light,
  output logic [N_CH-1:0] stop_light,
  output logic [N_CH-1:0] req_pending
);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
    crosswalk_chan #(
      .WALK_TIME  (WALK_TIME),
      .BLINK_DIV  (BLINK_DIV),
      .CLEAR_TIME (CLEAR_TIME),
      .TIMER_W    (TIMER_W)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .red          (red_trffc_light[ch]),
      .ylw          (ylw_trffc_light[ch]),
      .grn          (grn_trffc_light[ch]),
      .cross_button (cross_button[ch]),
      .walk_light   (walk_light[ch]),
      .stop_light   (stop_light[ch]),
      .req_pending  (req_pending[ch])
    );
  end

endmodule
